synchro: RTL and testbench

SYNCHRO -- requirements
Module: synchro

---
 rtl/synchro.sv | 54 +++++
 tb/tb_synchro.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/synchro.sv
// synchro: per-lane multi-flop resynchronizer bringing foreign-domain bits into the clk domain.
// Defining SYNCHRO_EDGE_DETECT_EN adds the sync_rise / sync_fall one-cycle edge outputs.
module synchro #(
  parameter string INITIALIZE = "LOGIC0",
  parameter int    STAGES     = 2,
  parameter int    WIDTH      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async,
`ifdef SYNCHRO_EDGE_DETECT_EN
  output logic [WIDTH-1:0] sync_rise,
  output logic [WIDTH-1:0] sync_fall,
`endif
  output logic [WIDTH-1:0] sync
);

  localparam logic INIT_BIT = (INITIALIZE == "LOGIC1");

  if (STAGES < 2 || STAGES > 8 || WIDTH < 1) begin : g_bad_params
    $error("synchro: STAGES must be within 2..8 and WIDTH must be at least 1");
  end

  // chain[0] is the capture stage; only chain[STAGES-1] leaves the chain.
  (* ASYNC_REG = "TRUE", keep = "true" *)
  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {(STAGES*WIDTH){INIT_BIT}};
    end else begin
      chain <= {chain[STAGES-2:0], async};
    end
  end

  assign sync = chain[STAGES-1];

`ifdef SYNCHRO_EDGE_DETECT_EN
  logic [WIDTH-1:0] hist;

  // History resets to the same value as the chain, so release never reports an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= {WIDTH{INIT_BIT}};
    end else begin
      hist <= sync;
    end
  end

  assign sync_rise = sync & ~hist;
  assign sync_fall = ~sync & hist;
`endif

endmodule

// File: tb/tb_synchro.sv
// tb_synchro: checks two synchro configurations against a sample-history reference model.
module tb_synchro;

  localparam int SA = 2;
  localparam int WA = 4;
  localparam int SB = 4;
  localparam int WB = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WA-1:0] async_a;
  logic [WA-1:0] sync_a;
  logic [WB-1:0] async_b;
  logic [WB-1:0] sync_b;
`ifdef SYNCHRO_EDGE_DETECT_EN
  logic [WA-1:0] rise_a, fall_a;
  logic [WB-1:0] rise_b, fall_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #100 clk = ~clk;

  synchro #(.INITIALIZE("LOGIC0"), .STAGES(SA), .WIDTH(WA)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .async    (async_a),
`ifdef SYNCHRO_EDGE_DETECT_EN
    .sync_rise(rise_a),
    .sync_fall(fall_a),
`endif
    .sync     (sync_a)
  );

  synchro #(.INITIALIZE("LOGIC1"), .STAGES(SB), .WIDTH(WB)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .async    (async_b),
`ifdef SYNCHRO_EDGE_DETECT_EN
    .sync_rise(rise_b),
    .sync_fall(fall_b),
`endif
    .sync     (sync_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: every value async held at a clk edge since reset; sync shows the one from STAGES edges back.
  logic [WA-1:0] hist_a[$];
  logic [WB-1:0] hist_b[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_a.delete();
      hist_b.delete();
    end else begin
      hist_a.push_back(async_a);
      hist_b.push_back(async_b);
    end
  end

  function automatic logic [WA-1:0] ref_a(input int back);
    int idx;
    idx = hist_a.size() - SA - back;
    return (idx < 0) ? '0 : hist_a[idx];
  endfunction

  function automatic logic [WB-1:0] ref_b(input int back);
    int idx;
    idx = hist_b.size() - SB - back;
    return (idx < 0) ? '1 : hist_b[idx];
  endfunction

  always @(negedge clk) begin
    check("a_sync", 32'(sync_a), 32'(ref_a(0)));
    check("b_sync", 32'(sync_b), 32'(ref_b(0)));
`ifdef SYNCHRO_EDGE_DETECT_EN
    check("a_rise", 32'(rise_a), 32'(ref_a(0) & ~ref_a(1)));
    check("a_fall", 32'(fall_a), 32'(~ref_a(0) & ref_a(1)));
    check("b_rise", 32'(rise_b), 32'(ref_b(0) & ~ref_b(1)));
    check("b_fall", 32'(fall_b), 32'(~ref_b(0) & ref_b(1)));
`endif
  end

  initial begin
    rst_n   = 1'b1;
    async_a = '1;
    async_b = '0;
    #10 rst_n = 1'b0;
    #1;
    check("rst_a", 32'(sync_a), 32'h0);
    check("rst_b", 32'(sync_b), 32'h1);
`ifdef SYNCHRO_EDGE_DETECT_EN
    check("rst_edges", 32'({rise_a, fall_a, rise_b, fall_b}), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk); check("a_lat1", 32'(sync_a), 32'h0);
    @(negedge clk); check("a_lat2", 32'(sync_a), 32'hF);
    @(negedge clk); check("b_hold3", 32'(sync_b), 32'h1);
    @(negedge clk); check("b_drop4", 32'(sync_b), 32'h0);

    async_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("b_lat_low", 32'(sync_b), 32'h0);
    end
    @(negedge clk); check("b_lat_high", 32'(sync_b), 32'h1);
    async_b = 1'b0;
    repeat (4) @(negedge clk);
    check("b_back_low", 32'(sync_b), 32'h0);

    // Mid-cycle reset: outputs must jump to INITIALIZE with no clk edge.
    #20;
    rst_n   = 1'b0;
    async_a = 4'b1010;
    #1;
    check("b_async_rst", 32'(sync_b), 32'h1);
    check("a_async_rst", 32'(sync_a), 32'h0);
    #20 rst_n = 1'b1;
    @(negedge clk); check("a_lanes1", 32'(sync_a), 32'h0);
    @(negedge clk); check("a_lanes2", 32'(sync_a), 32'hA);

    // Toggles land on odd times, clk edges on even ones, so no toggle coincides with a capture edge.
    fork
      begin
        #1;
        repeat (400) begin
          async_a = WA'($urandom);
          async_b = WB'($urandom);
          #74;
        end
      end
      begin
        #12040 rst_n = 1'b0;
        #30 rst_n = 1'b1;
      end
    join

    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
